usb_packet_fifo: RTL and testbench
==================================

// Module: usb_packet_fifo
// PURPOSE
//  Parametrised endpoint FIFO with packet commit/rollback on both sides; successor to fifo8x16.
//  OUT endpoints: the SIE writes speculatively, then commits on a good packet or rolls back on CRC/PID error.
//  IN endpoints: the SIE reads speculatively, then commits on host ACK or rolls back to retransmit on timeout.
//  Uncommitted data is invisible to the opposite side. Drop-in for the if_fifo signal set plus commit ports.
// PARAMETERS
//  WIDTH  8   data word width in bits
//  DEPTH  16  number of words; power of two, >=2; AW = $clog2(DEPTH)
// PORTS
//  clk          in   1       system clock; single clock domain
//  reset        in   1       synchronous, active-high reset
//  sclr         in   1       synchronous clear (same effect as reset, memory excepted)
//  data         in   WIDTH   write data
//  wrreq        in   1       write request
//  wr_commit    in   1       make all speculative writes (incl. this cycle's) readable
//  wr_rollback  in   1       discard all uncommitted writes
//  rdreq        in   1       read request
//  rd_commit    in   1       release space of all speculative reads (incl. this cycle's)
//  rd_rollback  in   1       rewind read pointer to last committed read
//  q            out  WIDTH   read data, registered
//  empty        out  1       no committed unread word available to read
//  full         out  1       no space for a write
//  usedw        out  AW+1    committed words not yet read (0..DEPTH, no wrap)
//  overflow     out  1       sticky: a write was attempted while full
// BEHAVIOUR
//  State: mem[DEPTH]; AW+1-bit pointers wr_ptr, wr_cptr, rd_ptr, rd_cptr; modulo-2^(AW+1) arithmetic.
//  Reset/sclr (sclr checked only when reset low; either beats all other inputs): all pointers 0,
//   q=0, empty=1, full=0, usedw=0, overflow=0. Memory not cleared.
//  Flags are combinational from registered pointers:
//   full = (wr_ptr-rd_cptr)==DEPTH; empty = (wr_cptr==rd_ptr); usedw = wr_cptr-rd_ptr.
//  Write accepted iff wrreq & !full & !wr_rollback: mem[wr_ptr[AW-1:0]]<=data, wr_ptr++.
//  wrreq & full: word dropped, overflow<=1 (sticky until sclr/reset or wr_rollback).
//  wr_rollback: wr_ptr<=wr_cptr, overflow<=0; takes priority over wrreq and wr_commit.
//  wr_commit (no rollback): wr_cptr<=next wr_ptr (includes a write accepted this cycle).
//  Read accepted iff rdreq & !empty & !rd_rollback: q<=mem[rd_ptr[AW-1:0]] next cycle
//   (1-cycle latency), rd_ptr++. q holds its value when no read is accepted.
//  rdreq & empty: ignored, q holds, no flag.
//  rd_rollback: rd_ptr<=rd_cptr; takes priority over rdreq and rd_commit.
//  rd_commit (no rollback): rd_cptr<=next rd_ptr (includes a read accepted this cycle).
//  Space is freed only by rd_commit; data becomes readable only by wr_commit.
//  Flags update the cycle after the causing event; a write and a read in the same cycle are
//   both accepted if permitted by the pre-cycle flags.
//  Pointer wrap at 2^(AW+1) is transparent; a full FIFO has wr_ptr/rd_cptr MSBs differing.
//  Mid-packet reset/sclr discards speculative and committed contents alike.
//  Tie wr_commit=1 and/or rd_commit=1 for plain-FIFO behaviour on that side.
// TESTING
//  1 reset: after reset, empty=1 full=0 usedw=0 q=0 overflow=0; sclr mid-traffic -> same values.
//  2 write 5 words 0x11..0x15 without commit -> empty=1,usedw=0; wr_commit -> usedw=5, empty=0
//    next cycle; 5 reads (rd_commit=1) return 0x11..0x15, q 1 cycle after each rdreq.
//  3 write 3 words, wr_rollback -> usedw=0, empty=1; next 2 committed writes 0xA0,0xA1 read back
//    as 0xA0,0xA1 (rolled-back data never appears).
//  4 IN retry: commit 4 words 0x01..0x04, read all 4 without rd_commit -> empty=1, full stays
//    dependent on rd_cptr; rd_rollback -> usedw=4; re-read returns 0x01..0x04; rd_commit -> space freed.
//  5 DEPTH=16: 16 writes -> full=1; 17th write dropped, overflow=1; read 1 without rd_commit
//    -> full stays 1; rd_commit -> full=0; wr_rollback clears overflow.
//  6 wrap/simultaneous: 40 words streamed with wrreq&rdreq every cycle, both commits tied high ->
//    data order intact across pointer wrap; wr_commit+wr_rollback same cycle -> rollback wins.

Source files
------------

// File: rtl/usb_packet_fifo.sv
// usb_packet_fifo: endpoint FIFO with speculative writes/reads that are committed or rolled back per packet.
// Committed write/read pointers bound what each side sees of the other side's traffic.
module usb_packet_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sclr,
    input  logic [WIDTH-1:0]         data,
    input  logic                     wrreq,
    input  logic                     wr_commit,
    input  logic                     wr_rollback,
    input  logic                     rdreq,
    input  logic                     rd_commit,
    input  logic                     rd_rollback,
    output logic [WIDTH-1:0]         q,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   usedw,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, wr_cptr, rd_ptr, rd_cptr;
    logic [AW:0] wr_span, wr_nxt, rd_nxt;
    logic wr_acc, rd_acc, clr;

    // Writers are limited by committed reads; readers only see committed writes.
    always_comb begin
        wr_span = wr_ptr - rd_cptr;
        full    = wr_span == FULL_CNT;
        empty   = wr_cptr == rd_ptr;
        usedw   = wr_cptr - rd_ptr;
        clr     = reset | sclr;
        wr_acc  = wrreq & ~full & ~wr_rollback;
        rd_acc  = rdreq & ~empty & ~rd_rollback;
        wr_nxt  = wr_ptr + {{AW{1'b0}}, wr_acc};
        rd_nxt  = rd_ptr + {{AW{1'b0}}, rd_acc};
    end

    always_ff @(posedge clk)
        if (wr_acc & ~clr) mem[wr_ptr[AW-1:0]] <= data;

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr   <= '0;
            wr_cptr  <= '0;
            rd_ptr   <= '0;
            rd_cptr  <= '0;
            q        <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_rollback) begin
                wr_ptr   <= wr_cptr;
                overflow <= 1'b0;
            end else begin
                wr_ptr <= wr_nxt;
                if (wr_commit) wr_cptr <= wr_nxt;
                if (wrreq & full) overflow <= 1'b1;
            end
            if (rd_rollback) begin
                rd_ptr <= rd_cptr;
            end else begin
                rd_ptr <= rd_nxt;
                if (rd_commit) rd_cptr <= rd_nxt;
                if (rd_acc) q <= mem[rd_ptr[AW-1:0]];
            end
        end
    end
endmodule

// File: tb/tb_usb_packet_fifo.sv
// tb_usb_packet_fifo: directed and random checks of usb_packet_fifo against a queue-based packet model.
module tb_usb_packet_fifo;
    logic clk = 0, reset = 1, sclr = 0;
    logic [7:0] data = 0;
    logic wrreq = 0, wr_commit = 0, wr_rollback = 0, rdreq = 0, rd_commit = 0, rd_rollback = 0;
    logic [7:0] q;
    logic empty, full, overflow;
    logic [4:0] usedw;
    int total = 0, bad = 0;

    usb_packet_fifo #(.WIDTH(8), .DEPTH(16)) dut (
        .clk(clk), .reset(reset), .sclr(sclr), .data(data), .wrreq(wrreq),
        .wr_commit(wr_commit), .wr_rollback(wr_rollback), .rdreq(rdreq),
        .rd_commit(rd_commit), .rd_rollback(rd_rollback), .q(q), .empty(empty),
        .full(full), .usedw(usedw), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Model: wq = uncommitted writes, cq = committed words still holding space, rpos = speculative reads into cq.
    logic [7:0] wq[$], cq[$];
    int rpos = 0;
    logic mo = 0;
    logic [7:0] mq = 0;

    function automatic bit m_full();
        return cq.size() + wq.size() == 16;
    endfunction
    function automatic bit m_empty();
        return rpos == cq.size();
    endfunction
    function automatic logic [4:0] m_used();
        return 5'(cq.size() - rpos);
    endfunction
    function automatic logic [15:0] m_exp();
        return {mq, m_empty(), m_full(), m_used(), mo};
    endfunction

    task automatic model_step(input bit w, input bit [7:0] d, input bit wc, wrb, r, rc, rrb, clr);
        bit f = m_full(), e = m_empty();
        if (clr) begin
            wq.delete(); cq.delete(); rpos = 0; mo = 0; mq = 0;
            return;
        end
        if (rrb) rpos = 0;
        else begin
            if (r && !e) begin mq = cq[rpos]; rpos++; end
            if (rc) begin repeat (rpos) void'(cq.pop_front()); rpos = 0; end
        end
        if (wrb) begin wq.delete(); mo = 0; end
        else begin
            if (w && !f) wq.push_back(d);
            if (w && f) mo = 1;
            if (wc) begin foreach (wq[i]) cq.push_back(wq[i]); wq.delete(); end
        end
    endtask

    task automatic tick(input bit w, input bit [7:0] d, input bit wc, wrb, r, rc, rrb, clr);
        wrreq = w; data = d; wr_commit = wc; wr_rollback = wrb;
        rdreq = r; rd_commit = rc; rd_rollback = rrb; sclr = clr;
        model_step(w, d, wc, wrb, r, rc, rrb, clr | reset);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        tick(0, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 0;
        total++;
        if ({q, empty, full, usedw, overflow} !== {8'h00, 1'b1, 1'b0, 5'd0, 1'b0}) begin
            bad++; $display("FAIL reset got=%h exp=%h", {q, empty, full, usedw, overflow}, {8'h00, 1'b1, 1'b0, 5'd0, 1'b0});
        end
        for (int i = 0; i < 6; i++) tick(1, 8'(8'h70 + i), 1, 0, i > 2, 1, 0, 0);
        tick(1, 8'h7F, 1, 0, 1, 1, 0, 1);
        total++;
        if ({q, empty, full, usedw, overflow} !== {8'h00, 1'b1, 1'b0, 5'd0, 1'b0}) begin
            bad++; $display("FAIL sclr got=%h exp=%h", {q, empty, full, usedw, overflow}, {8'h00, 1'b1, 1'b0, 5'd0, 1'b0});
        end
    endtask

    task automatic test_commit();
        for (int i = 0; i < 5; i++) tick(1, 8'(8'h11 + i), 0, 0, 0, 0, 0, 0);
        total++;
        if (usedw !== 5'd0 || empty !== 1'b1) begin
            bad++; $display("FAIL uncommitted usedw=%0d empty=%b exp usedw=0 empty=1", usedw, empty);
        end
        tick(0, 0, 1, 0, 0, 0, 0, 0);
        total++;
        if (usedw !== 5'd5 || empty !== 1'b0) begin
            bad++; $display("FAIL commit usedw=%0d empty=%b exp usedw=5 empty=0", usedw, empty);
        end
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0, 1, 1, 0, 0);
            total++;
            if (q !== 8'(8'h11 + i) || q !== mq) begin
                bad++; $display("FAIL commit_read i=%0d q=%h exp=%h", i, q, 8'(8'h11 + i));
            end
        end
    endtask

    task automatic test_rollback();
        for (int i = 0; i < 3; i++) tick(1, 8'(8'hC0 + i), 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0, 0, 0, 0);
        total++;
        if (usedw !== 5'd0 || empty !== 1'b1) begin
            bad++; $display("FAIL wr_rollback usedw=%0d empty=%b exp usedw=0 empty=1", usedw, empty);
        end
        tick(1, 8'hA0, 1, 0, 0, 0, 0, 0);
        tick(1, 8'hA1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            tick(0, 0, 0, 0, 1, 1, 0, 0);
            total++;
            if (q !== 8'(8'hA0 + i)) begin
                bad++; $display("FAIL rollback_read i=%0d q=%h exp=%h", i, q, 8'(8'hA0 + i));
            end
        end
    endtask

    task automatic test_in_retry();
        for (int i = 0; i < 4; i++) tick(1, 8'(8'h01 + i), 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 1, 0, 0, 0);
        total++;
        if (empty !== 1'b1 || usedw !== 5'd0 || full !== 1'b0) begin
            bad++; $display("FAIL spec_read empty=%b usedw=%0d full=%b exp 1 0 0", empty, usedw, full);
        end
        tick(0, 0, 0, 0, 0, 0, 1, 0);
        total++;
        if (usedw !== 5'd4) begin
            bad++; $display("FAIL rd_rollback usedw=%0d exp=4", usedw);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0, 1, 0, 0, 0);
            total++;
            if (q !== 8'(8'h01 + i)) begin
                bad++; $display("FAIL reread i=%0d q=%h exp=%h", i, q, 8'(8'h01 + i));
            end
        end
        for (int i = 0; i < 12; i++) tick(1, 8'(8'h40 + i), 1, 0, 0, 0, 0, 0);
        total++;
        if (full !== 1'b1) begin
            bad++; $display("FAIL retry_full full=%b exp=1", full);
        end
        tick(0, 0, 0, 0, 0, 1, 0, 0);
        total++;
        if (full !== 1'b0 || usedw !== 5'd12) begin
            bad++; $display("FAIL rd_commit full=%b usedw=%0d exp 0 12", full, usedw);
        end
        for (int i = 0; i < 12; i++) tick(0, 0, 0, 0, 1, 1, 0, 0);
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) tick(1, 8'(8'h30 + i), 1, 0, 0, 0, 0, 0);
        total++;
        if (full !== 1'b1 || usedw !== 5'd16 || overflow !== 1'b0) begin
            bad++; $display("FAIL full full=%b usedw=%0d ovf=%b exp 1 16 0", full, usedw, overflow);
        end
        tick(1, 8'hEE, 1, 0, 0, 0, 0, 0);
        total++;
        if (overflow !== 1'b1 || usedw !== 5'd16) begin
            bad++; $display("FAIL overflow ovf=%b usedw=%0d exp 1 16", overflow, usedw);
        end
        tick(0, 0, 0, 0, 1, 0, 0, 0);
        total++;
        if (full !== 1'b1 || q !== 8'h30) begin
            bad++; $display("FAIL full_hold full=%b q=%h exp 1 30", full, q);
        end
        tick(0, 0, 0, 0, 0, 1, 0, 0);
        total++;
        if (full !== 1'b0 || overflow !== 1'b1) begin
            bad++; $display("FAIL full_free full=%b ovf=%b exp 0 1", full, overflow);
        end
        tick(0, 0, 0, 1, 0, 0, 0, 0);
        total++;
        if (overflow !== 1'b0 || usedw !== 5'd15) begin
            bad++; $display("FAIL ovf_clear ovf=%b usedw=%0d exp 0 15", overflow, usedw);
        end
        for (int i = 0; i < 15; i++) begin
            tick(0, 0, 0, 0, 1, 1, 0, 0);
            total++;
            if (q !== 8'(8'h31 + i)) begin
                bad++; $display("FAIL full_drain i=%0d q=%h exp=%h", i, q, 8'(8'h31 + i));
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            tick(1, 8'($urandom), 1, 0, 1, 1, 0, 0);
            total++;
            if ({q, empty, full, usedw, overflow} !== m_exp()) begin
                bad++; $display("FAIL stream i=%0d got=%h exp=%h", i, {q, empty, full, usedw, overflow}, m_exp());
            end
        end
        for (int k = 0; k < 40 && m_used() != 0; k++) begin
            tick(0, 0, 0, 0, 1, 1, 0, 0);
            total++;
            if ({q, empty, full, usedw, overflow} !== m_exp()) begin
                bad++; $display("FAIL stream_drain k=%0d got=%h exp=%h", k, {q, empty, full, usedw, overflow}, m_exp());
            end
        end
        tick(1, 8'h55, 0, 0, 0, 0, 0, 0);
        tick(1, 8'h56, 0, 0, 0, 0, 0, 0);
        tick(1, 8'h66, 1, 1, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0, 0, 0);
        total++;
        if (usedw !== 5'd0 || empty !== 1'b1) begin
            bad++; $display("FAIL commit_vs_rollback usedw=%0d empty=%b exp 0 1", usedw, empty);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            tick($urandom % 2 == 0, 8'($urandom), $urandom % 4 == 0, $urandom % 16 == 0,
                 $urandom % 2 == 0, $urandom % 3 == 0, $urandom % 16 == 0, $urandom % 97 == 0);
            total++;
            if ({q, empty, full, usedw, overflow} !== m_exp()) begin
                bad++; $display("FAIL random i=%0d got=%h exp=%h", i, {q, empty, full, usedw, overflow}, m_exp());
            end
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_rollback();
        test_in_retry();
        test_full();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
